// File: rtl/snes_map_pkg.sv
// Shared definitions for the cartridge mapper bus arbiter.
//   IDLE_DI       : CPU read data presented while the bus is idle
//   arb_state_e   : arbiter FSM states (RUN / DRAIN)
//   onehot_to_idx : lowest-bit priority encode of coprocessor flags to a channel number
//   popcount_gt1  : true when more than one flag is set
package snes_map_pkg;

    localparam logic [7:0] IDLE_DI = 8'hFF;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_e;

    // Bit k-1 of v maps to channel k; the lowest set bit wins, no bits -> channel 0.
    function automatic logic [3:0] onehot_to_idx(input logic [14:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 15; i > 0; i--) begin
            if (v[i-1]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if there were two or more.
    function automatic logic popcount_gt1(input logic [14:0] v);
        return (v & (v - 15'd1)) != '0;
    endfunction

endpackage

// File: rtl/mapper_bus_arbiter_if.sv
// Bundle of mapper-channel inputs, shared ROM/BSRAM/CPU outputs and arbiter status.
//   master : arbiter view (channel signals in, shared bus and status out)
//   slave  : environment view (channel signals out, shared bus and status in)
// Per-channel vectors pack channel k at [k*W +: W].
interface mapper_bus_arbiter_if #(
    parameter int unsigned NUM_MAPS = 5,
    parameter int unsigned ROM_AW   = 24,
    parameter int unsigned BS_AW    = 20
);
    logic [NUM_MAPS-2:0]        map_active;
    logic [NUM_MAPS*8-1:0]      ch_do;
    logic [NUM_MAPS-1:0]        ch_irq_n;
    logic [NUM_MAPS*ROM_AW-1:0] ch_rom_addr;
    logic [NUM_MAPS-1:0]        ch_rom_ce_n;
    logic [NUM_MAPS-1:0]        ch_rom_oe_n;
    logic [NUM_MAPS-1:0]        ch_rom_word;
    logic [NUM_MAPS*BS_AW-1:0]  ch_bs_addr;
    logic [NUM_MAPS*8-1:0]      ch_bs_d;
    logic [NUM_MAPS-1:0]        ch_bs_ce_n;
    logic [NUM_MAPS-1:0]        ch_bs_oe_n;
    logic [NUM_MAPS-1:0]        ch_bs_we_n;

    logic [7:0]        di;
    logic              irq_n;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_ce_n;
    logic              rom_oe_n;
    logic              rom_word;
    logic [BS_AW-1:0]  bs_addr;
    logic [7:0]        bs_d;
    logic              bs_ce_n;
    logic              bs_oe_n;
    logic              bs_we_n;

    logic [3:0]        cur_sel;
    logic              switching;
    logic              multi_hot_err;
    logic [7:0]        switch_cnt;

    modport master (
        input  map_active, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n,
               ch_rom_word, ch_bs_addr, ch_bs_d, ch_bs_ce_n, ch_bs_oe_n, ch_bs_we_n,
        output di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word,
               bs_addr, bs_d, bs_ce_n, bs_oe_n, bs_we_n,
               cur_sel, switching, multi_hot_err, switch_cnt
    );

    modport slave (
        output map_active, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n,
               ch_rom_word, ch_bs_addr, ch_bs_d, ch_bs_ce_n, ch_bs_oe_n, ch_bs_we_n,
        input  di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word,
               bs_addr, bs_d, bs_ce_n, bs_oe_n, bs_we_n,
               cur_sel, switching, multi_hot_err, switch_cnt
    );
endinterface

// File: rtl/map_prio_enc.sv
// Priority encoder for coprocessor-active flags.
//   i_req   : flags, bit k-1 requests channel k (W <= 15)
//   o_idx   : channel number of the lowest set flag, 0 when none set
//   o_multi : more than one flag set
module map_prio_enc
    import snes_map_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_req,
    output logic [3:0]   o_idx,
    output logic         o_multi
);
    logic [14:0] w_req;

    assign w_req   = 15'(i_req);
    assign o_idx   = onehot_to_idx(w_req);
    assign o_multi = popcount_gt1(w_req);
endmodule

// File: rtl/mapper_bus_arbiter.sv
// Selects one of NUM_MAPS cartridge mapper channels onto the shared ROM/BSRAM/CPU bus.
// A change of selected channel first drains the bus (idle values) for DRAIN_CYCLES cycles.
//   mclk, rst_n : master clock, synchronous active-low reset
//   bus         : mapper_bus_arbiter_if.master (channel inputs, shared outputs, status)
// Parameters must match those of the connected interface instance.
module mapper_bus_arbiter
    import snes_map_pkg::*;
#(
    parameter int unsigned NUM_MAPS     = 5,
    parameter int unsigned ROM_AW       = 24,
    parameter int unsigned BS_AW        = 20,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter bit          REG_OUT      = 1'b1
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    mapper_bus_arbiter_if.master bus
);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    arb_state_e r_state, w_state_nx;
    logic [3:0] r_cur_sel, r_pend_sel, w_cur_nx, w_pend_nx;
    logic [3:0] w_target_raw, w_target, w_sel;
    logic [7:0] r_cnt, w_cnt_nx, r_switch_cnt;
    logic       w_commit, w_multi, r_multi_err;

    logic [7:0]        w_di, r_di;
    logic              w_irq_n, r_irq_n;
    logic [ROM_AW-1:0] w_rom_addr, r_rom_addr;
    logic              w_rom_ce_n, r_rom_ce_n, w_rom_oe_n, r_rom_oe_n, w_rom_word, r_rom_word;
    logic [BS_AW-1:0]  w_bs_addr, r_bs_addr;
    logic [7:0]        w_bs_d, r_bs_d;
    logic              w_bs_ce_n, r_bs_ce_n, w_bs_oe_n, r_bs_oe_n, w_bs_we_n, r_bs_we_n;

    map_prio_enc #(.W(NUM_MAPS - 1)) u_enc (
        .i_req   (bus.map_active),
        .o_idx   (w_target_raw),
        .o_multi (w_multi)
    );

    assign w_target = (32'(w_target_raw) < NUM_MAPS) ? w_target_raw : '0;
    assign w_sel    = (32'(r_cur_sel) < NUM_MAPS) ? r_cur_sel : '0;

    // State register
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_cur_sel    <= '0;
            r_pend_sel   <= '0;
            r_cnt        <= '0;
            r_switch_cnt <= '0;
            r_multi_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cur_sel   <= w_cur_nx;
            r_pend_sel  <= w_pend_nx;
            r_cnt       <= w_cnt_nx;
            r_multi_err <= r_multi_err | w_multi;
            if (w_commit && r_switch_cnt != 8'hFF) r_switch_cnt <= r_switch_cnt + 8'd1;
        end
    end

    // Next-state logic. pend_sel never equals cur_sel while draining, so a target
    // matching cur_sel is checked first as a cancel.
    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur_sel;
        w_pend_nx  = r_pend_sel;
        w_cnt_nx   = r_cnt;
        w_commit   = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_target != r_cur_sel) begin
                    w_pend_nx  = w_target;
                    w_cnt_nx   = DRAIN_LOAD;
                    w_state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (w_target == r_cur_sel) begin
                    w_state_nx = RUN;
                end else if (w_target != r_pend_sel) begin
                    w_pend_nx = w_target;
                    w_cnt_nx  = DRAIN_LOAD;
                end else if (r_cnt == '0) begin
                    w_cur_nx   = r_pend_sel;
                    w_commit   = 1'b1;
                    w_state_nx = RUN;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            default: w_state_nx = RUN;
        endcase
    end

    // Output mux. While draining, addresses and write data come from the output
    // registers so they hold whatever was last driven in RUN.
    always_comb begin
        int unsigned sel;
        sel        = 32'(w_sel);
        w_di       = IDLE_DI;
        w_irq_n    = 1'b1;
        w_rom_addr = r_rom_addr;
        w_rom_ce_n = 1'b1;
        w_rom_oe_n = 1'b1;
        w_rom_word = 1'b0;
        w_bs_addr  = r_bs_addr;
        w_bs_d     = r_bs_d;
        w_bs_ce_n  = 1'b1;
        w_bs_oe_n  = 1'b1;
        w_bs_we_n  = 1'b1;
        if (r_state == RUN) begin
            w_di       = bus.ch_do[sel*8 +: 8];
            w_irq_n    = bus.ch_irq_n[sel];
            w_rom_addr = bus.ch_rom_addr[sel*ROM_AW +: ROM_AW];
            w_rom_ce_n = bus.ch_rom_ce_n[sel];
            w_rom_oe_n = bus.ch_rom_oe_n[sel];
            w_rom_word = bus.ch_rom_word[sel];
            w_bs_addr  = bus.ch_bs_addr[sel*BS_AW +: BS_AW];
            w_bs_d     = bus.ch_bs_d[sel*8 +: 8];
            w_bs_ce_n  = bus.ch_bs_ce_n[sel];
            w_bs_oe_n  = bus.ch_bs_oe_n[sel];
            w_bs_we_n  = bus.ch_bs_we_n[sel];
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_di       <= IDLE_DI;
            r_irq_n    <= 1'b1;
            r_rom_addr <= '0;
            r_rom_ce_n <= 1'b1;
            r_rom_oe_n <= 1'b1;
            r_rom_word <= 1'b0;
            r_bs_addr  <= '0;
            r_bs_d     <= '0;
            r_bs_ce_n  <= 1'b1;
            r_bs_oe_n  <= 1'b1;
            r_bs_we_n  <= 1'b1;
        end else begin
            r_di       <= w_di;
            r_irq_n    <= w_irq_n;
            r_rom_addr <= w_rom_addr;
            r_rom_ce_n <= w_rom_ce_n;
            r_rom_oe_n <= w_rom_oe_n;
            r_rom_word <= w_rom_word;
            r_bs_addr  <= w_bs_addr;
            r_bs_d     <= w_bs_d;
            r_bs_ce_n  <= w_bs_ce_n;
            r_bs_oe_n  <= w_bs_oe_n;
            r_bs_we_n  <= w_bs_we_n;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            assign bus.di       = r_di;
            assign bus.irq_n    = r_irq_n;
            assign bus.rom_addr = r_rom_addr;
            assign bus.rom_ce_n = r_rom_ce_n;
            assign bus.rom_oe_n = r_rom_oe_n;
            assign bus.rom_word = r_rom_word;
            assign bus.bs_addr  = r_bs_addr;
            assign bus.bs_d     = r_bs_d;
            assign bus.bs_ce_n  = r_bs_ce_n;
            assign bus.bs_oe_n  = r_bs_oe_n;
            assign bus.bs_we_n  = r_bs_we_n;
        end else begin : g_comb_out
            assign bus.di       = w_di;
            assign bus.irq_n    = w_irq_n;
            assign bus.rom_addr = w_rom_addr;
            assign bus.rom_ce_n = w_rom_ce_n;
            assign bus.rom_oe_n = w_rom_oe_n;
            assign bus.rom_word = w_rom_word;
            assign bus.bs_addr  = w_bs_addr;
            assign bus.bs_d     = w_bs_d;
            assign bus.bs_ce_n  = w_bs_ce_n;
            assign bus.bs_oe_n  = w_bs_oe_n;
            assign bus.bs_we_n  = w_bs_we_n;
        end
    endgenerate

    assign bus.cur_sel       = r_cur_sel;
    assign bus.switching     = (r_state == DRAIN);
    assign bus.multi_hot_err = r_multi_err;
    assign bus.switch_cnt    = r_switch_cnt;
endmodule

// File: tb/tb_mapper_bus_arbiter.sv
// Self-checking bench for mapper_bus_arbiter (NUM_MAPS=5, DRAIN_CYCLES=4, REG_OUT=1).
module tb_mapper_bus_arbiter;
    localparam int NM = 5;
    localparam int RA = 24;
    localparam int BA = 20;
    localparam int DC = 4;

    typedef struct packed {
        logic [7:0]  di;
        logic        irq_n;
        logic [23:0] rom_addr;
        logic        rom_ce_n;
        logic        rom_oe_n;
        logic        rom_word;
        logic [19:0] bs_addr;
        logic [7:0]  bs_d;
        logic        bs_ce_n;
        logic        bs_oe_n;
        logic        bs_we_n;
    } out_t;

    typedef struct {
        logic        rst_n;
        logic [3:0]  act;
        logic [3:0]  cur;
        logic        sw;
        logic [7:0]  cnt;
        logic        err;
        logic        ce_n;
        logic [7:0]  di;
        logic [23:0] addr;
    } vec_t;

    logic mclk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 mclk = ~mclk;

    mapper_bus_arbiter_if #(.NUM_MAPS(NM), .ROM_AW(RA), .BS_AW(BA)) bus ();

    mapper_bus_arbiter #(
        .NUM_MAPS(NM), .ROM_AW(RA), .BS_AW(BA), .DRAIN_CYCLES(DC), .REG_OUT(1'b1)
    ) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: channel in use, target being drained toward and how many
    // idle cycles remain before it takes over the bus.
    int   m_cur, m_pend, m_left, m_cnt;
    bit   m_drain, m_err;
    out_t m_out;

    function automatic out_t idle_out(input out_t prev, input bit zero_addr);
        out_t o;
        o = prev;
        o.di = 8'hFF; o.irq_n = 1'b1;
        o.rom_ce_n = 1'b1; o.rom_oe_n = 1'b1; o.rom_word = 1'b0;
        o.bs_ce_n = 1'b1; o.bs_oe_n = 1'b1; o.bs_we_n = 1'b1;
        if (zero_addr) begin
            o.rom_addr = '0; o.bs_addr = '0; o.bs_d = '0;
        end
        return o;
    endfunction

    function automatic out_t chan_out(input int k);
        out_t o;
        o.di       = bus.ch_do[k*8 +: 8];
        o.irq_n    = bus.ch_irq_n[k];
        o.rom_addr = bus.ch_rom_addr[k*RA +: RA];
        o.rom_ce_n = bus.ch_rom_ce_n[k];
        o.rom_oe_n = bus.ch_rom_oe_n[k];
        o.rom_word = bus.ch_rom_word[k];
        o.bs_addr  = bus.ch_bs_addr[k*BA +: BA];
        o.bs_d     = bus.ch_bs_d[k*8 +: 8];
        o.bs_ce_n  = bus.ch_bs_ce_n[k];
        o.bs_oe_n  = bus.ch_bs_oe_n[k];
        o.bs_we_n  = bus.ch_bs_we_n[k];
        return o;
    endfunction

    function automatic out_t dut_out();
        return {bus.di, bus.irq_n, bus.rom_addr, bus.rom_ce_n, bus.rom_oe_n, bus.rom_word,
                bus.bs_addr, bus.bs_d, bus.bs_ce_n, bus.bs_oe_n, bus.bs_we_n};
    endfunction

    task automatic model_clock(input logic rst, input logic [3:0] act);
        int tgt, ones;
        tgt = 0;
        ones = 0;
        for (int b = 3; b >= 0; b--) begin
            if (act[b]) begin
                tgt = b + 1;
                ones++;
            end
        end
        if (!rst) begin
            m_out = idle_out(m_out, 1'b1);
            m_cur = 0; m_pend = 0; m_left = 0; m_cnt = 0; m_drain = 0; m_err = 0;
            return;
        end
        m_out = m_drain ? idle_out(m_out, 1'b0) : chan_out(m_cur);
        if (ones > 1) m_err = 1;
        if (!m_drain) begin
            if (tgt != m_cur) begin
                m_drain = 1; m_pend = tgt; m_left = DC;
            end
        end else if (tgt == m_cur) begin
            m_drain = 0;
        end else if (tgt != m_pend) begin
            m_pend = tgt; m_left = DC;
        end else if (m_left == 1) begin
            m_cur = m_pend; m_drain = 0;
            if (m_cnt < 255) m_cnt++;
        end else begin
            m_left--;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] act);
        rst_n = rst;
        bus.map_active = act;
        @(posedge mclk);
        model_clock(rst, act);
        #1;
        check("model_bus", 128'(dut_out()), 128'(m_out));
        check("model_cur_sel", 128'(bus.cur_sel), 128'(m_cur));
        check("model_switching", 128'(bus.switching), 128'(m_drain));
        check("model_switch_cnt", 128'(bus.switch_cnt), 128'(m_cnt));
        check("model_multi_hot_err", 128'(bus.multi_hot_err), 128'(m_err));
    endtask

    task automatic set_fixed_channels();
        for (int k = 0; k < NM; k++) begin
            bus.ch_do[k*8 +: 8]        = 8'h10 + 8'(k);
            bus.ch_irq_n[k]            = (k != 3);
            bus.ch_rom_addr[k*RA +: RA] = 24'h008000 | (24'(k) << 16);
            bus.ch_rom_ce_n[k]         = 1'b0;
            bus.ch_rom_oe_n[k]         = 1'b0;
            bus.ch_rom_word[k]         = k[0];
            bus.ch_bs_addr[k*BA +: BA] = 20'(k * 20'h01001);
            bus.ch_bs_d[k*8 +: 8]      = 8'hA0 + 8'(k);
            bus.ch_bs_ce_n[k]          = 1'b0;
            bus.ch_bs_oe_n[k]          = k[0];
            bus.ch_bs_we_n[k]          = ~k[0];
        end
    endtask

    task automatic rand_channels();
        for (int k = 0; k < NM; k++) begin
            bus.ch_do[k*8 +: 8]        = 8'($urandom);
            bus.ch_irq_n[k]            = 1'($urandom);
            bus.ch_rom_addr[k*RA +: RA] = 24'($urandom);
            bus.ch_rom_ce_n[k]         = 1'($urandom);
            bus.ch_rom_oe_n[k]         = 1'($urandom);
            bus.ch_rom_word[k]         = 1'($urandom);
            bus.ch_bs_addr[k*BA +: BA] = 20'($urandom);
            bus.ch_bs_d[k*8 +: 8]      = 8'($urandom);
            bus.ch_bs_ce_n[k]          = 1'($urandom);
            bus.ch_bs_oe_n[k]          = 1'($urandom);
            bus.ch_bs_we_n[k]          = 1'($urandom);
        end
    endtask

    vec_t vecs[15];

    initial begin
        rst_n = 1'b0;
        bus.map_active = '0;
        m_out = '0;
        set_fixed_channels();

        // rst, act, cur, sw, cnt, err, rom_ce_n, di, rom_addr (values after the edge)
        vecs[0]  = '{1'b0, 4'h0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'hFF, 24'h000000};
        vecs[1]  = '{1'b0, 4'h0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'hFF, 24'h000000};
        vecs[2]  = '{1'b1, 4'h0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h10, 24'h008000};
        vecs[3]  = '{1'b1, 4'h4, 4'd0, 1'b1, 8'd0, 1'b0, 1'b0, 8'h10, 24'h008000};
        vecs[4]  = '{1'b1, 4'h4, 4'd0, 1'b1, 8'd0, 1'b0, 1'b1, 8'hFF, 24'h008000};
        vecs[5]  = '{1'b1, 4'h4, 4'd0, 1'b1, 8'd0, 1'b0, 1'b1, 8'hFF, 24'h008000};
        vecs[6]  = '{1'b1, 4'h4, 4'd0, 1'b1, 8'd0, 1'b0, 1'b1, 8'hFF, 24'h008000};
        vecs[7]  = '{1'b1, 4'h4, 4'd3, 1'b0, 8'd1, 1'b0, 1'b1, 8'hFF, 24'h008000};
        vecs[8]  = '{1'b1, 4'h4, 4'd3, 1'b0, 8'd1, 1'b0, 1'b0, 8'h13, 24'h038000};
        vecs[9]  = '{1'b1, 4'h6, 4'd3, 1'b1, 8'd1, 1'b1, 1'b0, 8'h13, 24'h038000};
        vecs[10] = '{1'b1, 4'h2, 4'd3, 1'b1, 8'd1, 1'b1, 1'b1, 8'hFF, 24'h038000};
        vecs[11] = '{1'b1, 4'h2, 4'd3, 1'b1, 8'd1, 1'b1, 1'b1, 8'hFF, 24'h038000};
        vecs[12] = '{1'b1, 4'h2, 4'd3, 1'b1, 8'd1, 1'b1, 1'b1, 8'hFF, 24'h038000};
        vecs[13] = '{1'b1, 4'h2, 4'd2, 1'b0, 8'd2, 1'b1, 1'b1, 8'hFF, 24'h038000};
        vecs[14] = '{1'b1, 4'h2, 4'd2, 1'b0, 8'd2, 1'b1, 1'b0, 8'h12, 24'h028000};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst_n, vecs[i].act);
            check($sformatf("vec%0d_cur_sel", i), 128'(bus.cur_sel), 128'(vecs[i].cur));
            check($sformatf("vec%0d_switching", i), 128'(bus.switching), 128'(vecs[i].sw));
            check($sformatf("vec%0d_switch_cnt", i), 128'(bus.switch_cnt), 128'(vecs[i].cnt));
            check($sformatf("vec%0d_multi_hot_err", i), 128'(bus.multi_hot_err), 128'(vecs[i].err));
            check($sformatf("vec%0d_rom_ce_n", i), 128'(bus.rom_ce_n), 128'(vecs[i].ce_n));
            check($sformatf("vec%0d_di", i), 128'(bus.di), 128'(vecs[i].di));
            check($sformatf("vec%0d_rom_addr", i), 128'(bus.rom_addr), 128'(vecs[i].addr));
        end

        // Drain restart: head for channel 1, redirect to channel 4 at counter 2.
        step(1'b0, 4'h0);
        step(1'b1, 4'h0);
        step(1'b1, 4'h1);
        step(1'b1, 4'h1);
        step(1'b1, 4'h8);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h8);
            check("restart_still_draining", 128'(bus.switching), 128'(1));
            check("restart_cur_sel_held", 128'(bus.cur_sel), 128'(0));
        end
        step(1'b1, 4'h8);
        check("restart_cur_sel", 128'(bus.cur_sel), 128'(4));
        check("restart_switch_cnt", 128'(bus.switch_cnt), 128'(1));
        check("restart_switching", 128'(bus.switching), 128'(0));

        // Cancel: leave channel 4, then come back before the drain finishes.
        step(1'b1, 4'h2);
        step(1'b1, 4'h2);
        check("cancel_draining", 128'(bus.switching), 128'(1));
        step(1'b1, 4'h8);
        check("cancel_switching", 128'(bus.switching), 128'(0));
        check("cancel_cur_sel", 128'(bus.cur_sel), 128'(4));
        check("cancel_switch_cnt", 128'(bus.switch_cnt), 128'(1));
        step(1'b1, 4'h8);
        check("cancel_rom_addr", 128'(bus.rom_addr), 128'(24'h048000));

        // Reset in the middle of a drain, then release with a request still pending.
        step(1'b1, 4'h2);
        step(1'b1, 4'h6);
        step(1'b0, 4'h2);
        check("rst_switching", 128'(bus.switching), 128'(0));
        check("rst_cur_sel", 128'(bus.cur_sel), 128'(0));
        check("rst_switch_cnt", 128'(bus.switch_cnt), 128'(0));
        check("rst_multi_hot_err", 128'(bus.multi_hot_err), 128'(0));
        check("rst_strobes_n", 128'({bus.rom_ce_n, bus.rom_oe_n, bus.bs_ce_n, bus.bs_oe_n,
                                     bus.bs_we_n, bus.irq_n, bus.rom_word}), 128'(7'b1111110));
        check("rst_rom_addr", 128'(bus.rom_addr), 128'(0));
        check("rst_di", 128'(bus.di), 128'(8'hFF));
        step(1'b1, 4'h2);
        check("release_drain_starts", 128'(bus.switching), 128'(1));
        check("release_cur_sel", 128'(bus.cur_sel), 128'(0));

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; ) begin
            int r, len;
            logic [3:0] act;
            logic rst;
            r = int'($urandom_range(0, 9));
            if (r < 3) act = 4'h0;
            else if (r < 9) act = 4'(1 << $urandom_range(0, 3));
            else act = 4'($urandom);
            len = int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++) begin
                rst = ($urandom_range(0, 199) != 0);
                rand_channels();
                step(rst, act);
                n++;
            end
        end

        // Saturation: 300 committed switches alternating between channels 1 and 2.
        set_fixed_channels();
        step(1'b0, 4'h0);
        for (int s = 0; s < 300; s++) begin
            for (int j = 0; j < DC + 2; j++) step(1'b1, (s % 2 == 0) ? 4'h1 : 4'h2);
        end
        check("sat_switch_cnt", 128'(bus.switch_cnt), 128'(255));
        check("sat_cur_sel", 128'(bus.cur_sel), 128'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
